// File: rtl/i2c_wm8978_master.sv
// Write-only I2C master for the WM8978 codec control bus.
// Each accepted command produces one 3-byte write: {SLAVE_ADDR, W}, i2c_data[15:8], i2c_data[7:0].
// Optional feature macro: I2C_NACK_RETRY_EN (NACK restarts the transfer up to MAX_RETRY times).
module i2c_wm8978_master #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned I2C_FREQ   = 250_000,
    parameter logic [6:0]  SLAVE_ADDR = 7'h1A,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i2c_exec,
    input  logic [15:0] i2c_data,
    output logic        i2c_done,
    output logic        i2c_ack,
    output logic        busy,
    output logic        scl,
    inout  wire         sda
);

    // Clock cycles per quarter scl period.
    localparam int unsigned DIV  = CLK_FREQ / (4 * I2C_FREQ);
    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StAddr,
        StAck1,
        StDataH,
        StAck2,
        StDataL,
        StAck3,
        StStop,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      phase_q, phase_d;
    logic [2:0]      bit_q, bit_d;
    logic [15:0]     shreg_q, shreg_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ack_q, ack_d;
    // NACK seen in the current attempt; steers the ACK slot to STOP.
    logic            nack_q, nack_d;

`ifdef I2C_NACK_RETRY_EN
    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RetryW-1:0] retry_q, retry_d;
`endif

    logic       accept;
    logic       tick;
    logic       bit_end;
    logic       ack_slot;
    logic       sda_oe;
    logic       scl_mid;
    logic [7:0] tx_byte;

    assign accept   = (state_q == StIdle) && !busy_q && i2c_exec;
    assign tick     = busy_q && (div_q == DivW'(DIV - 1));
    assign bit_end  = tick && (phase_q == 2'd3);
    assign ack_slot = (state_q == StAck1) || (state_q == StAck2) || (state_q == StAck3);

    // Tick divider: cleared on accept, free-running while busy.
    always_comb begin
        div_d = div_q;
        if (accept) begin
            div_d = '0;
        end else if (busy_q) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
    end

    // State register and all sequential state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            div_q   <= '0;
            phase_q <= 2'd0;
            bit_q   <= 3'd0;
            shreg_q <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            nack_q  <= 1'b0;
`ifdef I2C_NACK_RETRY_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            nack_q  <= nack_d;
`ifdef I2C_NACK_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    // Next-state logic: bit sequencing, ACK sampling, command accept and completion.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ack_d   = ack_q;
        nack_d  = nack_q;
`ifdef I2C_NACK_RETRY_EN
        retry_d = retry_q;
`endif

        // busy covers the i2c_done cycle and drops right after it.
        if (done_q) begin
            busy_d = 1'b0;
        end

        if (tick) begin
            phase_d = phase_q + 2'd1;
        end

        // ACK is sampled at the end of ph2 while scl is high; a released line means NACK.
        if (tick && ack_slot && (phase_q == 2'd2) && (sda != 1'b0)) begin
            nack_d = 1'b1;
            ack_d  = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shreg_d = i2c_data;
                    busy_d  = 1'b1;
                    ack_d   = 1'b0;
                    nack_d  = 1'b0;
                    phase_d = 2'd0;
                    bit_d   = 3'd0;
                    state_d = StStart;
`ifdef I2C_NACK_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            StStart: begin
                if (bit_end) begin
                    bit_d   = 3'd0;
                    state_d = StAddr;
                end
            end
            StAddr, StDataH, StDataL: begin
                if (bit_end) begin
                    // 3-bit counter wraps 7 -> 0 as the byte finishes.
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        unique case (state_q)
                            StAddr:  state_d = StAck1;
                            StDataH: state_d = StAck2;
                            default: state_d = StAck3;
                        endcase
                    end
                end
            end
            StAck1: begin
                if (bit_end) begin
                    state_d = nack_q ? StStop : StDataH;
                end
            end
            StAck2: begin
                if (bit_end) begin
                    state_d = nack_q ? StStop : StDataL;
                end
            end
            StAck3: begin
                if (bit_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StDone;
`ifdef I2C_NACK_RETRY_EN
                    // Restart from START with the same shreg; i2c_ack reflects the latest attempt.
                    if (nack_q && (32'(retry_q) < MAX_RETRY)) begin
                        retry_d = retry_q + RetryW'(1);
                        nack_d  = 1'b0;
                        ack_d   = 1'b0;
                        state_d = StStart;
                    end
`endif
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Bus drivers: scl push-pull, sda open-drain, both decoded from state and phase.
    always_comb begin
        scl     = 1'b1;
        sda_oe  = 1'b0;
        scl_mid = (phase_q == 2'd1) || (phase_q == 2'd2);
        tx_byte = {SLAVE_ADDR, 1'b0};

        unique case (state_q)
            StStart: begin
                scl    = (phase_q != 2'd3);
                sda_oe = phase_q[1];
            end
            StAddr, StDataH, StDataL: begin
                if (state_q == StDataH) begin
                    tx_byte = shreg_q[15:8];
                end else if (state_q == StDataL) begin
                    tx_byte = shreg_q[7:0];
                end
                scl    = scl_mid;
                // MSB first: bit counter 0 selects bit 7.
                sda_oe = !tx_byte[~bit_q];
            end
            StAck1, StAck2, StAck3: begin
                scl = scl_mid;
            end
            StStop: begin
                scl    = (phase_q != 2'd0);
                sda_oe = (phase_q < 2'd2);
            end
            default: begin
                scl    = 1'b1;
                sda_oe = 1'b0;
            end
        endcase
    end

    assign sda      = sda_oe ? 1'b0 : 1'bz;
    assign i2c_done = done_q;
    assign i2c_ack  = ack_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_wm8978_master.sv
// Bench for i2c_wm8978_master: pulled-up sda, slave model that ACKs address 0x1A,
// DIV forced to 2 through CLK_FREQ/I2C_FREQ.
`timescale 1ns/1ps
module tb_i2c_wm8978_master;

    localparam int unsigned CLK_FREQ  = 8;
    localparam int unsigned I2C_FREQ  = 1;
    localparam int unsigned DIV       = 2;
    localparam int unsigned MAX_RETRY = 3;
    localparam int          LIMIT     = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i2c_exec;
    logic [15:0] i2c_data;
    logic        i2c_done;
    logic        i2c_ack;
    logic        busy;
    logic        scl;
    wire         sda;
    logic        slave_oe = 1'b0;

    assign sda = slave_oe ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_wm8978_master #(
        .CLK_FREQ  (CLK_FREQ),
        .I2C_FREQ  (I2C_FREQ),
        .SLAVE_ADDR(7'h1A),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i2c_exec(i2c_exec),
        .i2c_data(i2c_data),
        .i2c_done(i2c_done),
        .i2c_ack (i2c_ack),
        .busy    (busy),
        .scl     (scl),
        .sda     (sda)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- slave / bus monitor ----------------
    logic [7:0] got_q[$];
    int         start_cnt = 0;
    int         stop_cnt  = 0;
    int         done_cnt  = 0;
    int         addr_seen = 0;
    int         nack_budget = 0;
    int         addr_base   = 0;
    bit         slv_rst_tgl  = 1'b0;
    bit         slv_rst_seen = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         bcnt = 0;
    logic [7:0] shift = 8'h00;
    bit         first_byte = 1'b0;
    bit         in_frame = 1'b0;
    bit         ack_now = 1'b0;

    always @(negedge clk) begin
        if (i2c_done === 1'b1) done_cnt++;
        if (slv_rst_tgl != slv_rst_seen) begin
            slv_rst_seen = slv_rst_tgl;
            bcnt     = 0;
            slave_oe = 1'b0;
            in_frame = 1'b0;
        end else if (prev_scl === 1'b1 && scl === 1'b1 && prev_sda === 1'b1 && sda === 1'b0) begin
            start_cnt++;
            bcnt       = 0;
            first_byte = 1'b1;
            in_frame   = 1'b1;
            slave_oe   = 1'b0;
        end else if (prev_scl === 1'b1 && scl === 1'b1 && prev_sda === 1'b0 && sda === 1'b1) begin
            stop_cnt++;
            in_frame = 1'b0;
            slave_oe = 1'b0;
        end else if (prev_scl === 1'b0 && scl === 1'b1 && in_frame) begin
            if (bcnt < 8) shift = {shift[6:0], sda};
            bcnt++;
            if (bcnt == 8) begin
                got_q.push_back(shift);
                if (first_byte) begin
                    ack_now = (shift == 8'h34) && ((addr_seen - addr_base) >= nack_budget);
                    addr_seen++;
                end else begin
                    ack_now = 1'b1;
                end
                first_byte = 1'b0;
            end
        end else if (prev_scl === 1'b1 && scl === 1'b0 && in_frame) begin
            if (bcnt == 8) begin
                slave_oe = ack_now;
            end else if (bcnt == 9) begin
                slave_oe = 1'b0;
                bcnt     = 0;
            end
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    // ---------------- reference model ----------------
    // Transaction-level view: each attempt is a START, the address byte and its ACK,
    // then either both data bytes (29 bits in total) or straight to STOP (11 bits).
    logic [7:0] exp_q[$];

    task automatic model(input logic [15:0] d, input int nacks,
                         output int bits, output bit ack, output int starts);
        int att;
        exp_q.delete();
`ifdef I2C_NACK_RETRY_EN
        att = (nacks > int'(MAX_RETRY)) ? int'(MAX_RETRY) + 1 : nacks + 1;
`else
        att = 1;
`endif
        bits = 0;
        for (int i = 0; i < att; i++) begin
            exp_q.push_back(8'h34);
            if (i >= nacks) begin
                exp_q.push_back(d[15:8]);
                exp_q.push_back(d[7:0]);
                bits += 29;
            end else begin
                bits += 11;
            end
        end
        ack    = (att <= nacks);
        starts = att;
    endtask

    // Runs one transaction starting at a negedge; returns at the negedge after i2c_done,
    // so a following call issues exec in the cycle right after i2c_done.
    task automatic do_txn(input logic [15:0] d, input int nacks, input int exp_bits,
                          input bit exp_ack, input bit noise, input bit junk_at_done,
                          input string tag);
        int m_bits, m_starts, cyc, bbase, sbase, dbase, n;
        bit m_ack;
        model(d, nacks, m_bits, m_ack, m_starts);
        nack_budget = nacks;
        addr_base   = addr_seen;
        bbase       = got_q.size();
        sbase       = start_cnt;
        dbase       = done_cnt;

        i2c_data = d;
        i2c_exec = 1'b1;
        @(negedge clk);
        i2c_exec = 1'b0;
        i2c_data = 16'hDEAD;
        check({tag, "_busy_accept"}, busy, 1);

        cyc = 0;
        while (i2c_done !== 1'b1 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            i2c_exec = noise && (cyc % 37 == 0);
        end
        check({tag, "_latency"}, cyc, exp_bits * 4 * DIV + 1);
        check({tag, "_ack"}, i2c_ack, exp_ack);
        check({tag, "_busy_done"}, busy, 1);

        // exec during the i2c_done cycle must be ignored.
        i2c_exec = junk_at_done;
        i2c_data = 16'hBEEF;
        @(negedge clk);
        i2c_exec = 1'b0;
        check({tag, "_busy_clear"}, busy, 0);
        check({tag, "_done_pulse"}, i2c_done, 0);
        check({tag, "_done_count"}, done_cnt - dbase, 1);
        check({tag, "_starts"}, start_cnt - sbase, m_starts);
        n = got_q.size() - bbase;
        check({tag, "_nbytes"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            check($sformatf("%s_byte%0d", tag, i), got_q[bbase + i], exp_q[i]);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        int          nacks;
        int          bits;
        bit          ack;
        bit          noise;
        bit          junk;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int   dbase, r_bits, r_starts, r_n;
        bit   r_ack;
        logic [15:0] r_d;

        // Expected values worked out by hand from the transfer rules.
        vecs[0] = '{16'h0E00, 0, 29, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h1234, 0, 29, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{16'hFFFF, 0, 29, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h0000, 0, 29, 1'b0, 1'b0, 1'b1};
`ifdef I2C_NACK_RETRY_EN
        vecs[4] = '{16'h0E00, 1, 40, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'hABCD, 5, 44, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'h8001, 3, 62, 1'b0, 1'b0, 1'b0};
`else
        vecs[4] = '{16'h0E00, 1, 11, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'hABCD, 5, 11, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'h8001, 3, 11, 1'b1, 1'b0, 1'b0};
`endif

        rst      = 1'b1;
        i2c_exec = 1'b0;
        i2c_data = 16'h0000;
        slv_rst_tgl = ~slv_rst_tgl;
        repeat (3) @(negedge clk);
        check("rst_scl", scl, 1);
        check("rst_sda", sda, 1);
        check("rst_busy", busy, 0);
        check("rst_done", i2c_done, 0);
        check("rst_ack", i2c_ack, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table vectors back to back: each exec lands in the cycle after the previous i2c_done.
        for (int v = 0; v < 7; v++) begin
            do_txn(vecs[v].data, vecs[v].nacks, vecs[v].bits, vecs[v].ack,
                   vecs[v].noise, vecs[v].junk, $sformatf("vec%0d", v));
        end

        // Randomized commands against the reference model.
        for (int k = 0; k < 8; k++) begin
            r_d = 16'($urandom);
            r_n = int'($urandom_range(0, 4));
            model(r_d, r_n, r_bits, r_ack, r_starts);
            do_txn(r_d, r_n, r_bits, r_ack, k[0], k[1], $sformatf("rand%0d", k));
        end

        // Reset in the middle of DATA_H aborts without STOP or i2c_done.
        repeat (3) @(negedge clk);
        nack_budget = 0;
        addr_base   = addr_seen;
        dbase       = done_cnt;
        i2c_data    = 16'h5A5A;
        i2c_exec    = 1'b1;
        @(negedge clk);
        i2c_exec = 1'b0;
        repeat (11 * 4 * DIV + 3) @(negedge clk);
        check("midrst_busy_before", busy, 1);
        rst = 1'b1;
        slv_rst_tgl = ~slv_rst_tgl;
        @(negedge clk);
        check("midrst_scl", scl, 1);
        check("midrst_sda", sda, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", i2c_done, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_done", done_cnt - dbase, 0);
        do_txn(16'hC3A5, 0, 29, 1'b0, 1'b0, 1'b0, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
